// File: rtl/gascon_pkg.sv
// Shared types and the Gascon round function for the DryGASCON squeeze path.
// The round is an Ascon-style S-box and linear layer on five 64-bit words.
package gascon_pkg;

  localparam int GASCON_CWIDTH = 320;
  localparam int RATE_BITS     = 128;
  localparam int ACC_SLICES    = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAITGAS = 3'd3,
    ACCUM   = 3'd4,
    DONE    = 3'd5
  } squeeze_state_t;

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [GASCON_CWIDTH-1:0] gascon_round(
    input logic [GASCON_CWIDTH-1:0] s,
    input logic [3:0]               rnd
  );
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    {x4, x3, x2, x1, x0} = s;
    // round constant lands in the middle word: (0xf - rnd) << 4 | rnd
    x2 = x2 ^ {56'h0, ~rnd, rnd};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ rotr64(x0, 19) ^ rotr64(x0, 28);
    x1 = x1 ^ rotr64(x1, 61) ^ rotr64(x1, 38);
    x2 = x2 ^ rotr64(x2, 1)  ^ rotr64(x2, 6);
    x3 = x3 ^ rotr64(x3, 10) ^ rotr64(x3, 17);
    x4 = x4 ^ rotr64(x4, 7)  ^ rotr64(x4, 40);
    return {x4, x3, x2, x1, x0};
  endfunction

endpackage

// File: rtl/gascon_core_round.sv
// Iterative Gascon core: ROUND_COUNT rounds per enable burst, done in the last
// enabled cycle, so the core latency equals ROUND_COUNT cycles of en.
module Gascon_Core_Round
  import gascon_pkg::*;
#(
  parameter int CWIDTH      = GASCON_CWIDTH,
  parameter int ROUND_COUNT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        round,
  input  logic [CWIDTH-1:0] c_in,
  output logic [CWIDTH-1:0] c_out,
  output logic              done
);

  localparam int CNTW = (ROUND_COUNT > 1) ? $clog2(ROUND_COUNT) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(ROUND_COUNT - 1);

  logic [CNTW-1:0]   cnt;
  logic [CWIDTH-1:0] s;
  logic [CWIDTH-1:0] src;

  // first round works on the caller's state, later rounds on the held result
  assign src   = (cnt == '0) ? c_in : s;
  assign c_out = gascon_round(src, round + 4'(cnt));
  assign done  = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      s   <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNTW'(1);
        s   <= c_out;
      end
    end
  end

endmodule

// File: rtl/g_squeeze128.sv
// Squeeze stage: runs the Gascon round over the state and folds the low 256
// bits into a 128-bit output block after every round.
module g_squeeze128
  import gascon_pkg::*;
#(
  parameter  int CWIDTH     = GASCON_CWIDTH,
  parameter  int MAX_ROUNDS = 12,
  localparam int RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CWIDTH-1:0] c,
  input  logic [RW-1:0]     rounds,
  output logic [CWIDTH-1:0] cout,
  output logic [127:0]      r,
  output logic              done,
  output logic              busy
);

  localparam logic [RW-1:0] MAX_R = RW'(MAX_ROUNDS);

  squeeze_state_t    state;
  logic [CWIDTH-1:0] c_reg;
  logic [127:0]      r_reg;
  logic [RW-1:0]     j;
  logic [RW-1:0]     n_rounds;

  logic              gas_reset;
  logic              gas_en;
  logic              gas_done;
  logic [CWIDTH-1:0] gas_out;
  logic [127:0]      r_acc;
  logic [RW-1:0]     j_inc;
  logic [RW-1:0]     rounds_sat;

  assign gas_reset  = (state == START);
  assign gas_en     = (state == WAITGAS);
  assign j_inc      = j + RW'(1);
  assign rounds_sat = (rounds > MAX_R) ? MAX_R : rounds;

  always_comb begin
    r_acc = r_reg;
    for (int i = 0; i < ACC_SLICES; i++) begin
      r_acc = r_acc ^ c_reg[i*RATE_BITS +: RATE_BITS];
    end
  end

  Gascon_Core_Round #(
    .CWIDTH      (CWIDTH),
    .ROUND_COUNT (1)
  ) u_core (
    .clk   (clk),
    .reset (reset | gas_reset),
    .en    (gas_en),
    .round (4'(j)),
    .c_in  (c_reg),
    .c_out (gas_out),
    .done  (gas_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      c_reg    <= '0;
      r_reg    <= '0;
      j        <= '0;
      n_rounds <= '0;
      cout     <= '0;
      r        <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (en) begin
            state    <= LOAD;
            c_reg    <= c;
            n_rounds <= rounds_sat;
            r_reg    <= '0;
            j        <= '0;
            cout     <= '0;
            r        <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (n_rounds == '0) begin
            state <= DONE;
            cout  <= c_reg;
            r     <= r_reg;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= START;
          end
        end
        START: state <= WAITGAS;
        WAITGAS: begin
          if (gas_done) begin
            c_reg <= gas_out;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          r_reg <= r_acc;
          j     <= j_inc;
          if (j_inc == n_rounds) begin
            state <= DONE;
            cout  <= c_reg;
            r     <= r_acc;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
